// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path: widths common with the
// sample ROM, the sequencer state encoding and the silence value.
package audio_pkg;

  localparam int AUDIO_ADDR_W = 14;
  localparam int AUDIO_DATA_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  localparam logic [AUDIO_DATA_W-1:0] SAMPLE_SILENCE = 16'h0000;

endpackage : audio_pkg

// File: rtl/sample_rate_divider.sv
// Free-running clock divider: emits a one-cycle tick every CLK_DIV enabled
// clocks. Shared by the sequencer and the downstream PWM stage.
module sample_rate_divider #(
  parameter int DIV_W   = 16,
  parameter int CLK_DIV = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count_q, count_d;

  assign tick = enable && (count_q == LAST_COUNT);

  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : sample_rate_divider

// File: rtl/audio_sample_sequencer.sv
// Steps a registered ROM address through a programmed window at the sample
// rate, latches each ROM word and strobes it to the DAC/PWM stage.
module audio_sample_sequencer
  import audio_pkg::*;
#(
  parameter int ADDR_W  = AUDIO_ADDR_W,
  parameter int DATA_W  = AUDIO_DATA_W,
  parameter int DIV_W   = 16,
  parameter int CLK_DIV = 1250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                tick;

  // Any play or stop restarts the sample period from zero.
  sample_rate_divider #(
    .DIV_W  (DIV_W),
    .CLK_DIV(CLK_DIV)
  ) u_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (play | stop),
    .enable(state_q == ST_PLAY),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    start_d  = start_q;
    end_d    = end_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    // Priority: stop over play over tick; a discarded tick produces no strobe.
    if (stop) begin
      state_d  = ST_IDLE;
      sample_d = DATA_W'(SAMPLE_SILENCE);
    end else if (play) begin
      state_d = ST_PLAY;
      start_d = start_addr;
      end_d   = end_addr;
      addr_d  = start_addr;
    end else if (state_q == ST_PLAY && tick) begin
      sample_d = rom_data;
      valid_d  = 1'b1;
      if (addr_q != end_q) begin
        addr_d = addr_q + ADDR_W'(1);
      end else if (loop_en) begin
        addr_d = start_q;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      start_q  <= '0;
      end_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      end_q    <= end_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign busy         = (state_q == ST_PLAY);

endmodule : audio_sample_sequencer

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer with CLK_DIV=4 and a ROM model
// holding ROM[k] = k*3.
module tb_audio_sample_sequencer;

  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 16;
  localparam int DIV_W   = 16;
  localparam int CLK_DIV = 4;

  logic              clk;
  logic              rst_n;
  logic              play;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  audio_sample_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .play        (play),
    .stop        (stop),
    .loop_en     (loop_en),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done)
  );

  assign rom_data = DATA_W'(32'(rom_addr) * 3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_play(input int s, input int e);
    start_addr = ADDR_W'(s);
    end_addr   = ADDR_W'(e);
    play       = 1'b1;
    step();
    play       = 1'b0;
  endtask

  // Advance one sample period and check the strobe lands on the last edge only.
  task automatic expect_sample(input string tag, input int smp, input bit dn, input int addr);
    repeat (CLK_DIV - 1) step();
    check({tag, ".early"}, 32'(sample_valid), 0);
    step();
    check({tag, ".valid"}, 32'(sample_valid), 1);
    check({tag, ".sample"}, 32'(sample_out), 32'(smp));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".addr"}, 32'(rom_addr), 32'(addr));
  endtask

  initial begin
    rst_n      = 1'b0;
    play       = 1'b0;
    stop       = 1'b0;
    loop_en    = 1'b0;
    start_addr = '0;
    end_addr   = '0;

    #2;
    check("rst.addr", 32'(rom_addr), 0);
    check("rst.sample", 32'(sample_out), 0);
    check("rst.valid", 32'(sample_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("idle.busy", 32'(busy), 0);
    check("idle.valid", 32'(sample_valid), 0);

    // One-shot window 10..12.
    do_play(10, 12);
    check("os.busy", 32'(busy), 1);
    check("os.addr0", 32'(rom_addr), 10);
    expect_sample("os.s0", 30, 1'b0, 11);
    expect_sample("os.s1", 33, 1'b0, 12);
    expect_sample("os.s2", 36, 1'b1, 12);
    step();
    check("os.busy_end", 32'(busy), 0);
    check("os.done_end", 32'(done), 0);
    check("os.valid_end", 32'(sample_valid), 0);
    check("os.addr_hold", 32'(rom_addr), 12);
    repeat (4) step();
    check("os.idle_valid", 32'(sample_valid), 0);

    // Looped window, then drop loop_en to finish at the end address.
    loop_en = 1'b1;
    do_play(10, 12);
    expect_sample("lp.s0", 30, 1'b0, 11);
    expect_sample("lp.s1", 33, 1'b0, 12);
    expect_sample("lp.s2", 36, 1'b0, 10);
    expect_sample("lp.s3", 30, 1'b0, 11);
    expect_sample("lp.s4", 33, 1'b0, 12);
    check("lp.busy", 32'(busy), 1);
    loop_en = 1'b0;
    expect_sample("lp.s5", 36, 1'b1, 12);
    check("lp.busy_end", 32'(busy), 0);
    step();

    // Window crossing the top of the address space.
    do_play(16382, 1);
    check("wr.addr0", 32'(rom_addr), 16382);
    expect_sample("wr.s0", 49146, 1'b0, 16383);
    expect_sample("wr.s1", 49149, 1'b0, 0);
    expect_sample("wr.s2", 0, 1'b0, 1);
    expect_sample("wr.s3", 3, 1'b1, 1);
    step();

    // Stop coinciding with a tick.
    do_play(10, 12);
    expect_sample("st.s0", 30, 1'b0, 11);
    repeat (CLK_DIV - 1) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("st.valid", 32'(sample_valid), 0);
    check("st.done", 32'(done), 0);
    check("st.sample", 32'(sample_out), 0);
    check("st.busy", 32'(busy), 0);

    // Play and stop together from idle.
    start_addr = ADDR_W'(20);
    end_addr   = ADDR_W'(22);
    play       = 1'b1;
    stop       = 1'b1;
    step();
    play       = 1'b0;
    stop       = 1'b0;
    check("ps.busy", 32'(busy), 0);
    repeat (CLK_DIV + 1) step();
    check("ps.valid", 32'(sample_valid), 0);
    check("ps.busy2", 32'(busy), 0);

    // Restart two cycles before a tick with a new window.
    do_play(10, 12);
    step();
    do_play(100, 105);
    check("rp.addr", 32'(rom_addr), 100);
    step();
    step();
    check("rp.suppressed", 32'(sample_valid), 0);
    check("rp.busy", 32'(busy), 1);
    step();
    check("rp.early", 32'(sample_valid), 0);
    step();
    check("rp.valid", 32'(sample_valid), 1);
    check("rp.sample", 32'(sample_out), 300);
    check("rp.addr1", 32'(rom_addr), 101);
    check("rp.done", 32'(done), 0);

    // Asynchronous reset between clock edges while playing.
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("ar.addr", 32'(rom_addr), 0);
    check("ar.sample", 32'(sample_out), 0);
    check("ar.valid", 32'(sample_valid), 0);
    check("ar.busy", 32'(busy), 0);
    check("ar.done", 32'(done), 0);
    step();
    rst_n = 1'b1;
    repeat (CLK_DIV + 2) step();
    check("ar.idle_busy", 32'(busy), 0);
    check("ar.idle_valid", 32'(sample_valid), 0);
    check("ar.idle_addr", 32'(rom_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_audio_sample_sequencer

// File: doc/audio_sample_sequencer.md
Name: audio_sample_sequencer

Overview:
Address generator and sample latch that sits directly upstream of the 16K x 16 audio sample ROM (14-bit address in, 16-bit data out, combinational read). It steps a read pointer through a programmed address window at a fixed sample rate derived from the system clock. It latches each ROM word and presents it with a one-cycle valid strobe to the downstream DAC/PWM stage. It supports one-shot and looped playback with play/stop control.

Parameters:
ADDR_W, 14, ROM address width (16384 entries)
DATA_W, 16, sample width (two's complement)
DIV_W, 16, width of sample-rate divider counter
CLK_DIV, 1250, system clocks per sample (10 MHz / 8 kHz); legal range 2..2^DIV_W-1

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
play  in  1  single-cycle pulse: start/restart playback
stop  in  1  single-cycle pulse: abort playback
loop_en  in  1  1 = wrap to start at end of window; sampled at every end-of-window event
start_addr  in  ADDR_W  first sample address, captured on accepted play
end_addr  in  ADDR_W  last sample address (inclusive), captured on accepted play
rom_addr  out  ADDR_W  address driven to ROM
rom_data  in  DATA_W  ROM read data, combinational from rom_addr
sample_out  out  DATA_W  latched sample for downstream stage
sample_valid  out  1  one-cycle strobe, sample_out updated this cycle
busy  out  1  high while in PLAY state
done  out  1  one-cycle pulse on natural (non-loop) end of window

Behaviour:
- Reset is asynchronous and active-low: rst_n is the only reset and acts immediately on assertion. While rst_n=0, all outputs are 0: rom_addr=0, sample_out=0, sample_valid=0, busy=0, done=0. Internal state is IDLE, divider=0, cur/start/end registers=0.
- States: IDLE, PLAY.
- IDLE: rom_addr holds its last value. sample_out holds its value. On play=1 and stop=0, capture start_addr/end_addr into internal regs, set rom_addr=start_addr, clear divider, go to PLAY. busy=1 from the next cycle.
- PLAY: divider increments each clock. A tick occurs in the cycle where divider==CLK_DIV-1; the divider then returns to 0. On the tick edge:
  - sample_out <= rom_data, which is the word at the current rom_addr.
  - sample_valid=1 for exactly the following cycle.
  - The address advances.
- Address advance:
  - If rom_addr != end_reg: rom_addr <= rom_addr+1 modulo 2^ADDR_W, so 16383 wraps to 0. end_addr < start_addr is therefore legal and plays across the wrap.
  - If rom_addr == end_reg and loop_en=1: rom_addr <= start_reg, remain in PLAY.
  - If rom_addr == end_reg and loop_en=0: go to IDLE and pulse done=1 in the same cycle as the final sample_valid. rom_addr holds end_reg.
- Latency: the first sample_valid asserts exactly CLK_DIV cycles after the cycle play was sampled high. Successive valids are exactly CLK_DIV cycles apart.
- start_addr == end_addr: a one-sample window. One-shot plays one sample then done. Loop repeats the same sample every CLK_DIV cycles.
- stop=1 in any state:
  - Go to IDLE next cycle, clear divider.
  - sample_out <= 0 (silence).
  - No sample_valid and no done that cycle, even if a tick coincides.
- stop and play in the same cycle: stop wins, play is ignored.
- play while in PLAY: restart. Recapture start/end, rom_addr=start_addr, divider=0, no done pulse. A coincident tick is discarded (no sample_valid).
- start_addr/end_addr changes while playing have no effect until the next accepted play.
- rom_addr is a register, never combinational from inputs. sample_out changes only on a tick or a stop.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_ADDR_W=14, AUDIO_DATA_W=16 (shared with the ROM).
  - State enum {ST_IDLE, ST_PLAY}.
  - Silence constant SAMPLE_SILENCE=16'h0000.
- One sub-module: sample_rate_divider, parameters DIV_W/CLK_DIV.
  - Inputs: clk, rst_n, clear, enable. Output: tick.
  - Counts only when enabled. Clear forces the count to 0.
  - Reused by the downstream PWM stage.
- Address and control FSM stay in the top module.

Test Plan:
- CLK_DIV=4, start=10, end=12, loop_en=0, ROM[k]=k*3; pulse play -> sample_valid at cycles 4, 8, 12 after play with sample_out 30, 33, 36; done with third valid; busy falls next cycle; rom_addr stays 12.
- Same window, loop_en=1 -> valid sequence 30, 33, 36, 30, 33 at 4-cycle spacing; no done; clear loop_en mid-run -> done on the next sample from addr 12.
- start=16382, end=1, loop_en=0 -> rom_addr sequence 16382, 16383, 0, 1; four valids then done.
- Stop on the exact tick cycle during playback -> no sample_valid, no done, sample_out=0 next cycle, busy=0; play and stop asserted together from IDLE -> stays IDLE.
- Play re-pulsed 2 cycles before a tick, with new start=100 -> that tick suppressed; next valid 4 cycles after the re-play carries ROM[100].
- Assert rst_n=0 asynchronously mid-PLAY (between clock edges) -> all outputs 0 immediately; after release, idle until play.
